// File: rtl/residual_seq.sv
// Macroblock residual sequencer: walks the H.264 residual block order of one MB,
// launches every coded block and reports each luma/chroma-AC slot's TotalCoeff.
module residual_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       mb_start,
  input  logic       mb_is_i16,
  input  logic [3:0] cbp_luma,
  input  logic [1:0] cbp_chroma,
  input  logic       residual_valid,
  input  logic [4:0] TotalCoeff,
  output logic       residual_start,
  output logic [3:0] residual_state,
  output logic [3:0] luma4x4BlkIdx_residual,
  output logic [1:0] chroma4x4BlkIdx_residual,
  output logic [4:0] max_coeff_num,
  output logic       start_of_MB,
  output logic       blk_done,
  output logic       blk_coded,
  output logic [4:0] blk_total_coeff,
  output logic       mb_done,
  output logic       busy
);

  localparam logic [2:0] FsmIdle  = 3'd0;
  localparam logic [2:0] FsmSel   = 3'd1;
  localparam logic [2:0] FsmIssue = 3'd2;
  localparam logic [2:0] FsmWait  = 3'd3;
  localparam logic [2:0] FsmDone  = 3'd4;

  localparam logic [3:0] StI16Dc  = 4'd0;
  localparam logic [3:0] StI16Ac  = 4'd1;
  localparam logic [3:0] StLuma   = 4'd2;
  localparam logic [3:0] StCbDc   = 4'd3;
  localparam logic [3:0] StCrDc   = 4'd4;
  localparam logic [3:0] StCbAc   = 4'd5;
  localparam logic [3:0] StCrAc   = 4'd6;
  localparam logic [3:0] StIdle   = 4'd15;

  logic [2:0] fsm_q, fsm_d;
  logic [3:0] slotState_q, slotState_d;
  logic [3:0] slotIdx_q, slotIdx_d;
  logic [3:0] cbpLuma_q, cbpLuma_d;
  logic [1:0] cbpChroma_q, cbpChroma_d;
  logic       resStart_q, resStart_d;
  logic       som_q, som_d;
  logic       blkDone_q, blkDone_d;
  logic       blkCoded_q, blkCoded_d;
  logic [4:0] blkTotal_q, blkTotal_d;
  logic       mbDone_q, mbDone_d;

  logic       slotCoded;
  logic       slotIsDc;
  logic       slotLast;
  logic [3:0] advState;
  logic [3:0] advIdx;

  // Per-slot decode: coded flag, DC-ness and the successor slot in residual order.
  always_comb begin
    slotCoded = 1'b0;
    slotIsDc  = 1'b0;
    slotLast  = 1'b0;
    advState  = slotState_q;
    advIdx    = slotIdx_q + 4'd1;
    case (slotState_q)
      StI16Dc: begin
        slotCoded = 1'b1;
        slotIsDc  = 1'b1;
        advState  = StI16Ac;
        advIdx    = 4'd0;
      end
      StI16Ac, StLuma: begin
        slotCoded = (slotState_q == StI16Ac) ? (cbpLuma_q == 4'hF)
                                             : cbpLuma_q[slotIdx_q[3:2]];
        if (slotIdx_q == 4'd15) begin
          advState = StCbDc;
          advIdx   = 4'd0;
        end
      end
      StCbDc, StCrDc: begin
        slotCoded = |cbpChroma_q;
        slotIsDc  = 1'b1;
        advState  = (slotState_q == StCbDc) ? StCrDc : StCbAc;
        advIdx    = 4'd0;
      end
      StCbAc: begin
        slotCoded = cbpChroma_q[1];
        if (slotIdx_q == 4'd3) begin
          advState = StCrAc;
          advIdx   = 4'd0;
        end
      end
      StCrAc: begin
        slotCoded = cbpChroma_q[1];
        if (slotIdx_q == 4'd3) begin
          slotLast = 1'b1;
          advIdx   = slotIdx_q;
        end
      end
      default: begin
        slotLast = 1'b1;
        advIdx   = slotIdx_q;
      end
    endcase
  end

  // Sequencer: pulses default low; skipped DC slots produce no report.
  always_comb begin
    fsm_d       = fsm_q;
    slotState_d = slotState_q;
    slotIdx_d   = slotIdx_q;
    cbpLuma_d   = cbpLuma_q;
    cbpChroma_d = cbpChroma_q;
    resStart_d  = 1'b0;
    som_d       = 1'b0;
    blkDone_d   = 1'b0;
    blkCoded_d  = 1'b0;
    blkTotal_d  = 5'd0;
    mbDone_d    = 1'b0;
    case (fsm_q)
      FsmIdle: begin
        if (mb_start) begin
          fsm_d       = FsmSel;
          som_d       = 1'b1;
          cbpLuma_d   = cbp_luma;
          cbpChroma_d = cbp_chroma;
          slotState_d = mb_is_i16 ? StI16Dc : StLuma;
          slotIdx_d   = 4'd0;
        end
      end
      FsmSel: begin
        if (slotCoded) begin
          fsm_d      = FsmIssue;
          resStart_d = 1'b1;
        end else begin
          blkDone_d   = !slotIsDc;
          slotState_d = advState;
          slotIdx_d   = advIdx;
          fsm_d       = slotLast ? FsmDone : FsmSel;
        end
      end
      FsmIssue: fsm_d = FsmWait;
      FsmWait: begin
        if (residual_valid) begin
          blkDone_d   = !slotIsDc;
          blkCoded_d  = !slotIsDc;
          blkTotal_d  = slotIsDc ? 5'd0 : TotalCoeff;
          slotState_d = advState;
          slotIdx_d   = advIdx;
          fsm_d       = slotLast ? FsmDone : FsmSel;
        end
      end
      FsmDone: begin
        mbDone_d = 1'b1;
        fsm_d    = FsmIdle;
      end
      default: fsm_d = FsmIdle;
    endcase
  end

  // With ena low every register, pulses included, keeps its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= FsmIdle;
      slotState_q <= StIdle;
      slotIdx_q   <= 4'd0;
      cbpLuma_q   <= 4'd0;
      cbpChroma_q <= 2'd0;
      resStart_q  <= 1'b0;
      som_q       <= 1'b0;
      blkDone_q   <= 1'b0;
      blkCoded_q  <= 1'b0;
      blkTotal_q  <= 5'd0;
      mbDone_q    <= 1'b0;
    end else if (ena) begin
      fsm_q       <= fsm_d;
      slotState_q <= slotState_d;
      slotIdx_q   <= slotIdx_d;
      cbpLuma_q   <= cbpLuma_d;
      cbpChroma_q <= cbpChroma_d;
      resStart_q  <= resStart_d;
      som_q       <= som_d;
      blkDone_q   <= blkDone_d;
      blkCoded_q  <= blkCoded_d;
      blkTotal_q  <= blkTotal_d;
      mbDone_q    <= mbDone_d;
    end
  end

  assign residual_state = (fsm_q == FsmIdle) ? StIdle : slotState_q;

  always_comb begin
    case (residual_state)
      StI16Dc, StLuma:         max_coeff_num = 5'd16;
      StI16Ac, StCbAc, StCrAc: max_coeff_num = 5'd15;
      StCbDc, StCrDc:          max_coeff_num = 5'd4;
      default:                 max_coeff_num = 5'd0;
    endcase
  end

  assign luma4x4BlkIdx_residual   = (residual_state == StI16Ac || residual_state == StLuma)
                                    ? slotIdx_q : 4'd0;
  assign chroma4x4BlkIdx_residual = (residual_state == StCbAc || residual_state == StCrAc)
                                    ? slotIdx_q[1:0] : 2'd0;

  assign residual_start  = resStart_q;
  assign start_of_MB     = som_q;
  assign blk_done        = blkDone_q;
  assign blk_coded       = blkCoded_q;
  assign blk_total_coeff = blkTotal_q;
  assign mb_done         = mbDone_q;
  // mb_done lands in the first IDLE cycle, so busy is stretched over it.
  assign busy            = (fsm_q != FsmIdle) | mbDone_q;

endmodule

// File: tb/tb_residual_seq.sv
// Directed bench for residual_seq: an auto-responder answers each block start,
// a negedge monitor logs starts and slot reports for per-MB checks.
module tb_residual_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       mb_start;
  logic       mb_is_i16;
  logic [3:0] cbp_luma;
  logic [1:0] cbp_chroma;
  logic       residual_valid;
  logic [4:0] TotalCoeff;
  logic       residual_start;
  logic [3:0] residual_state;
  logic [3:0] luma4x4BlkIdx_residual;
  logic [1:0] chroma4x4BlkIdx_residual;
  logic [4:0] max_coeff_num;
  logic       start_of_MB;
  logic       blk_done;
  logic       blk_coded;
  logic [4:0] blk_total_coeff;
  logic       mb_done;
  logic       busy;

  int totalCnt = 0;
  int badCnt = 0;

  int cyc = 0;
  int sc = 0;
  int bc = 0;
  int mdc = 0;
  int somCnt = 0;
  int somCyc = 0;
  int stCyc0 = 0;
  int lastBdCyc = 0;
  int mbDoneCyc = 0;
  int codedCnt = 0;
  int stS[64];
  int stL[64];
  int stC[64];
  int stM[64];
  int bdC[32];
  int bdT[32];

  residual_seq dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .ena                      (ena),
    .mb_start                 (mb_start),
    .mb_is_i16                (mb_is_i16),
    .cbp_luma                 (cbp_luma),
    .cbp_chroma               (cbp_chroma),
    .residual_valid           (residual_valid),
    .TotalCoeff               (TotalCoeff),
    .residual_start           (residual_start),
    .residual_state           (residual_state),
    .luma4x4BlkIdx_residual   (luma4x4BlkIdx_residual),
    .chroma4x4BlkIdx_residual (chroma4x4BlkIdx_residual),
    .max_coeff_num            (max_coeff_num),
    .start_of_MB              (start_of_MB),
    .blk_done                 (blk_done),
    .blk_coded                (blk_coded),
    .blk_total_coeff          (blk_total_coeff),
    .mb_done                  (mb_done),
    .busy                     (busy)
  );

  always #5 clk = ~clk;

  // Monitor: per-MB logs restart whenever start_of_MB is seen.
  always @(negedge clk) begin
    cyc++;
    if (start_of_MB) begin
      somCnt++;
      somCyc   = cyc;
      sc       = 0;
      bc       = 0;
      mdc      = 0;
      codedCnt = 0;
    end
    if (residual_start) begin
      if (sc < 64) begin
        stS[sc] = int'(residual_state);
        stL[sc] = int'(luma4x4BlkIdx_residual);
        stC[sc] = int'(chroma4x4BlkIdx_residual);
        stM[sc] = int'(max_coeff_num);
      end
      if (sc == 0) stCyc0 = cyc;
      sc++;
    end
    if (blk_done) begin
      if (bc < 32) begin
        bdC[bc] = int'(blk_coded);
        bdT[bc] = int'(blk_total_coeff);
      end
      if (blk_coded) codedCnt++;
      lastBdCyc = cyc;
      bc++;
    end
    if (mb_done) begin
      mdc++;
      mbDoneCyc = cyc;
    end
  end

  // Responder: answers start number n with TotalCoeff = n + 2, holds valid until taken with ena high.
  initial begin
    residual_valid = 1'b0;
    TotalCoeff     = 5'd0;
    forever begin
      @(negedge clk);
      if (residual_start) begin
        @(negedge clk);
        residual_valid = 1'b1;
        TotalCoeff     = 5'(sc + 2);
        do @(posedge clk); while (!ena);
        @(negedge clk);
        residual_valid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    totalCnt++;
    if (obs !== exp) begin
      badCnt++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic i16, input logic [3:0] luma, input logic [1:0] chroma);
    @(negedge clk);
    mb_is_i16  = i16;
    cbp_luma   = luma;
    cbp_chroma = chroma;
    mb_start   = 1'b1;
    @(negedge clk);
    mb_start   = 1'b0;
  endtask

  task automatic waitMbDone(input string tag);
    int n = 0;
    while (!mb_done && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!mb_done) begin
      checkOutput({tag, "_timeout"}, 0, 1);
    end else begin
      checkOutput({tag, "_busy_at_done"}, int'(busy), 1);
      @(negedge clk);
      #1;
      checkOutput({tag, "_busy_after"}, int'(busy), 0);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_state"}, int'(residual_state), 15);
    checkOutput({tag, "_max"}, int'(max_coeff_num), 0);
    checkOutput({tag, "_lidx"}, int'(luma4x4BlkIdx_residual), 0);
    checkOutput({tag, "_cidx"}, int'(chroma4x4BlkIdx_residual), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_start"}, int'(residual_start), 0);
    checkOutput({tag, "_bdone"}, int'(blk_done), 0);
    checkOutput({tag, "_coded"}, int'(blk_coded), 0);
    checkOutput({tag, "_total"}, int'(blk_total_coeff), 0);
    checkOutput({tag, "_mbdone"}, int'(mb_done), 0);
    checkOutput({tag, "_som"}, int'(start_of_MB), 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b1;
    mb_start   = 1'b0;
    mb_is_i16  = 1'b0;
    cbp_luma   = 4'd0;
    cbp_chroma = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkIdleOutputs("reset");

    // Luma4x4, only the first 8x8 coded, no chroma.
    applyStimulus(1'b0, 4'b0001, 2'd0);
    waitMbDone("t1");
    checkOutput("t1_starts", sc, 4);
    checkOutput("t1_first_start_lat", stCyc0 - somCyc, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t1_st_state%0d", i), stS[i], 2);
      checkOutput($sformatf("t1_st_idx%0d", i), stL[i], i);
      checkOutput($sformatf("t1_st_max%0d", i), stM[i], 16);
    end
    checkOutput("t1_reports", bc, 24);
    for (int i = 0; i < 24; i++) begin
      checkOutput($sformatf("t1_coded%0d", i), bdC[i], (i < 4) ? 1 : 0);
      checkOutput($sformatf("t1_total%0d", i), bdT[i], (i < 4) ? i + 3 : 0);
    end
    checkOutput("t1_mbdone", mdc, 1);
    checkOutput("t1_som", somCnt, 1);

    // Intra16x16 with everything coded.
    applyStimulus(1'b1, 4'hF, 2'd2);
    waitMbDone("t2");
    checkOutput("t2_starts", sc, 27);
    checkOutput("t2_dc_state", stS[0], 0);
    checkOutput("t2_dc_max", stM[0], 16);
    checkOutput("t2_ac0_state", stS[1], 1);
    checkOutput("t2_ac0_idx", stL[1], 0);
    checkOutput("t2_ac0_max", stM[1], 15);
    checkOutput("t2_ac15_state", stS[16], 1);
    checkOutput("t2_ac15_idx", stL[16], 15);
    checkOutput("t2_cbdc_state", stS[17], 3);
    checkOutput("t2_cbdc_max", stM[17], 4);
    checkOutput("t2_crdc_state", stS[18], 4);
    checkOutput("t2_crdc_max", stM[18], 4);
    checkOutput("t2_cbac0_state", stS[19], 5);
    checkOutput("t2_cbac0_cidx", stC[19], 0);
    checkOutput("t2_cbac0_max", stM[19], 15);
    checkOutput("t2_crac3_state", stS[26], 6);
    checkOutput("t2_crac3_cidx", stC[26], 3);
    checkOutput("t2_crac3_max", stM[26], 15);
    checkOutput("t2_reports", bc, 24);
    checkOutput("t2_coded", codedCnt, 24);
    checkOutput("t2_total_ac0", bdT[0], 4);
    checkOutput("t2_total_ac15", bdT[15], 19);
    checkOutput("t2_total_cbac0", bdT[16], 22);
    checkOutput("t2_total_crac3", bdT[23], 29);
    checkOutput("t2_mbdone", mdc, 1);

    // Intra16x16, no luma AC, chroma DC only.
    applyStimulus(1'b1, 4'h0, 2'd1);
    waitMbDone("t3");
    checkOutput("t3_starts", sc, 3);
    checkOutput("t3_st0", stS[0], 0);
    checkOutput("t3_st1", stS[1], 3);
    checkOutput("t3_st2", stS[2], 4);
    checkOutput("t3_max0", stM[0], 16);
    checkOutput("t3_max1", stM[1], 4);
    checkOutput("t3_max2", stM[2], 4);
    checkOutput("t3_reports", bc, 24);
    checkOutput("t3_coded", codedCnt, 0);
    checkOutput("t3_total5", bdT[5], 0);

    // Nothing coded: 26 one-cycle SEL steps, then DONE.
    applyStimulus(1'b0, 4'h0, 2'd0);
    waitMbDone("t4");
    checkOutput("t4_starts", sc, 0);
    checkOutput("t4_reports", bc, 24);
    checkOutput("t4_coded", codedCnt, 0);
    checkOutput("t4_last_report_lat", lastBdCyc - somCyc, 26);
    checkOutput("t4_mbdone_lat", mbDoneCyc - lastBdCyc, 1);

    // ena held low for 5 cycles while residual_valid is pending in WAIT.
    applyStimulus(1'b0, 4'b0001, 2'd0);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (!residual_start && n < 100);
      checkOutput("t5_first_start_seen", int'(residual_start), 1);
    end
    @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("t5_frz_state%0d", i), int'(residual_state), 2);
      checkOutput($sformatf("t5_frz_max%0d", i), int'(max_coeff_num), 16);
      checkOutput($sformatf("t5_frz_bdone%0d", i), int'(blk_done), 0);
      checkOutput($sformatf("t5_frz_busy%0d", i), int'(busy), 1);
    end
    ena = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("t5_resume_bdone", int'(blk_done), 1);
    checkOutput("t5_resume_coded", int'(blk_coded), 1);
    checkOutput("t5_resume_total", int'(blk_total_coeff), 3);
    waitMbDone("t5");
    checkOutput("t5_starts", sc, 4);
    checkOutput("t5_reports", bc, 24);
    checkOutput("t5_total1", bdT[1], 4);
    checkOutput("t5_total3", bdT[3], 6);
    checkOutput("t5_coded4", bdC[4], 0);
    checkOutput("t5_mbdone", mdc, 1);

    // Reset in the middle of chroma AC, then a normal MB.
    applyStimulus(1'b1, 4'hF, 2'd2);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (residual_state != 4'd5 && n < 500);
      checkOutput("t6_reached_cbac", int'(residual_state), 5);
    end
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    checkOutput("t6_no_mbdone", mdc, 0);
    checkOutput("t6_idle_busy", int'(busy), 0);
    applyStimulus(1'b0, 4'b0001, 2'd0);
    waitMbDone("t6");
    checkOutput("t6_starts", sc, 4);
    checkOutput("t6_reports", bc, 24);
    checkOutput("t6_mbdone", mdc, 1);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
